// File: rtl/upb_sched_pkg.sv
// Shared types for the packet round-robin scheduler: FSM state encoding and
// the rotating-priority pick used by the arbiter.
package upb_sched_pkg;

    localparam int max_ports = 8;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of cand, scanning ptr, ptr+1, ... and wrapping at num_ports.
    function automatic rr_pick_t rr_pick(input logic [max_ports-1:0] cand,
                                         input logic [2:0]           ptr,
                                         input int                   num_ports);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int i = 0; i < max_ports; i++) begin
            j = int'(ptr) + i;
            if (j >= num_ports) j -= num_ports;
            if (i < num_ports && !r.valid && cand[3'(j)]) begin
                r.valid = 1'b1;
                r.idx   = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/packet_rr_scheduler_if.sv
// Ingress FIFO read ports plus the shared egress FIFO write port.
// master = scheduler side, slave = FIFO/environment side.
interface packet_rr_scheduler_if #(
    parameter int num_ports      = 4,
    parameter int data_width     = 256,
    parameter int metadata_width = 32,
    parameter int src_width      = $clog2(num_ports)
) ();
    logic [num_ports*data_width-1:0]     in_data;
    logic [num_ports*metadata_width-1:0] in_metadata;
    logic [num_ports-1:0]                in_last;
    logic [num_ports-1:0]                in_empty;
    logic [num_ports-1:0]                in_rd;

    logic [data_width-1:0]               out_data;
    logic [metadata_width-1:0]           out_metadata;
    logic [src_width-1:0]                out_src;
    logic                                out_last;
    logic                                out_wr;
    logic                                out_almost_full;

    modport master (
        input  in_data, in_metadata, in_last, in_empty, out_almost_full,
        output in_rd, out_data, out_metadata, out_src, out_last, out_wr
    );

    modport slave (
        output in_data, in_metadata, in_last, in_empty, out_almost_full,
        input  in_rd, out_data, out_metadata, out_src, out_last, out_wr
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotating priority starting at ptr,
// wrapping at num_ports.
module rr_arbiter
    import upb_sched_pkg::*;
#(
    parameter int num_ports = 4,
    parameter int src_width = $clog2(num_ports)
) (
    input  logic [num_ports-1:0] cand,
    input  logic [src_width-1:0] ptr,
    output logic                 valid,
    output logic [src_width-1:0] idx
);
    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(max_ports'(cand), 3'(ptr), num_ports);
        valid = pick.valid;
        idx   = src_width'(pick.idx);
    end
endmodule

// File: rtl/packet_rr_scheduler.sv
// Packet-atomic round-robin scheduler: pops whole packets from one ingress
// FIFO at a time and forwards them through a single output register stage.
module packet_rr_scheduler
    import upb_sched_pkg::*;
#(
    parameter int num_ports      = 4,
    parameter int data_width     = 256,
    parameter int metadata_width = 32,
    parameter int src_width      = $clog2(num_ports)
) (
    input  logic                  clk,
    input  logic                  reset,
    packet_rr_scheduler_if.master bus,
    input  logic [num_ports-1:0]  port_enable,
    output logic [31:0]           pkt_count
);
    state_t                state_q, state_d;
    logic [src_width-1:0]  grant_q, grant_d;
    logic [src_width-1:0]  rr_ptr_q, rr_ptr_d;
    logic [src_width-1:0]  sel;
    logic                  pop;
    logic [num_ports-1:0]  cand;
    logic                  pick_valid;
    logic [src_width-1:0]  pick_idx;

    assign cand = ~bus.in_empty & port_enable;

    rr_arbiter #(.num_ports(num_ports), .src_width(src_width)) u_arb (
        .cand  (cand),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    function automatic logic [src_width-1:0] wrap_inc(input logic [src_width-1:0] p);
        return (int'(p) == num_ports - 1) ? '0 : p + 1'b1;
    endfunction

    // NOTE: in_rd is combinational, so reset must gate it here; the state
    // register alone would only take effect one cycle later.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        sel      = grant_q;
        pop      = 1'b0;
        if (!reset && !bus.out_almost_full) begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        sel     = pick_idx;
                        pop     = 1'b1;
                        grant_d = pick_idx;
                        if (bus.in_last[pick_idx]) rr_ptr_d = wrap_inc(pick_idx);
                        else                       state_d  = XFER;
                    end
                end
                XFER: begin
                    // Granted port keeps the bus until its last beat, enabled or not.
                    if (!bus.in_empty[grant_q]) begin
                        pop = 1'b1;
                        if (bus.in_last[grant_q]) begin
                            state_d  = IDLE;
                            rr_ptr_d = wrap_inc(grant_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_rd = '0;
        if (pop) bus.in_rd[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // NOTE: the wide data/metadata registers are reset too so the egress bus
    // reads as all-zero after reset rather than stale contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_wr       <= 1'b0;
            bus.out_last     <= 1'b0;
            bus.out_data     <= '0;
            bus.out_metadata <= '0;
            bus.out_src      <= '0;
            pkt_count        <= '0;
        end else begin
            bus.out_wr <= pop;
            if (pop) begin
                bus.out_data     <= bus.in_data[int'(sel)*data_width +: data_width];
                bus.out_metadata <= bus.in_metadata[int'(sel)*metadata_width +: metadata_width];
                bus.out_last     <= bus.in_last[sel];
                bus.out_src      <= sel;
            end
            if (bus.out_wr && bus.out_last) pkt_count <= pkt_count + 32'd1;
        end
    end
endmodule

// File: doc/packet_rr_scheduler.md
Name: packet_rr_scheduler

Overview:
Packet-atomic round-robin scheduler that shares one downstream simple packet FIFO write port among num_ports upstream simple packet FIFO read ports.
- Pops whole packets from the granted input, without interleaving, and forwards them through one output register stage.
- Sits between per-port ingress FIFOs and the shared egress/processing FIFO, in a single clock domain.

Parameters:
num_ports, 4, number of upstream FIFOs (2..8)
data_width, 256, data bus width per beat
metadata_width, 32, per-packet metadata width
src_width, $clog2(num_ports), width of source-port index

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
in_data  in  num_ports*data_width  per-port head data (FWFT)
in_metadata  in  num_ports*metadata_width  per-port head-packet metadata
in_last  in  num_ports  per-port head beat is last of packet
in_empty  in  num_ports  per-port FIFO empty
in_rd  out  num_ports  per-port pop strobe, one-hot or zero
port_enable  in  num_ports  port eligible for new grants
out_data  out  data_width  registered beat data
out_metadata  out  metadata_width  registered metadata of current packet
out_src  out  src_width  registered source port of current beat
out_last  out  1  registered last flag
out_wr  out  1  registered write strobe to downstream FIFO
out_almost_full  in  1  downstream almost-full
pkt_count  out  32  packets forwarded, wraps at 2^32

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - out_wr=0, out_last=0, out_data=0, out_metadata=0, out_src=0.
  - pkt_count=0, state=IDLE, rr_ptr=0, grant=0.
  - in_rd is combinational and is 0 during reset.
- Candidate vector: cand = ~in_empty & port_enable.
- Issue condition: issue = chosen/granted port not empty AND out_almost_full=0. in_rd[p]=issue for that port.
- State IDLE:
  - Choose the first set bit of cand, searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., num_ports-1, 0, ...).
  - If cand≠0 and out_almost_full=0: pop that port in the same cycle and set grant<=chosen.
  - If the popped beat has in_last=1 (single-beat packet): stay IDLE and set rr_ptr<=chosen+1 mod num_ports.
  - Otherwise go to XFER.
- State XFER:
  - Pop grant whenever ~in_empty[grant] and out_almost_full=0.
  - port_enable is ignored for the granted port; a packet always completes.
  - in_empty[grant]=1 mid-packet (cut-through upstream): wait with grant held; out_wr=0 that cycle.
  - Pop with in_last=1: go to IDLE and set rr_ptr<=grant+1 mod num_ports.
- Back-to-back packets: IDLE arbitrates in the cycle after a last beat, so there is no bubble beyond that one state transition. The last beat and the next first beat are in adjacent cycles.
- Output stage, one cycle latency:
  - Each pop in cycle t gives out_wr=1 in t+1, with out_data, out_metadata, out_last, out_src captured from the popped port.
  - No pop in cycle t gives out_wr=0 in t+1; data registers hold their value.
- Metadata: captured on every beat from the granted port's head metadata, so it is valid on the last beat, where the downstream store-and-forward FIFO samples it.
- pkt_count increments by 1 in the cycle out_wr&out_last=1.
- Backpressure: out_almost_full is honoured with one cycle of latency only. Downstream almost_full_offset must be ≥2 beats.
- Simultaneous events: a port becoming non-empty while the current packet ends is considered only in the next IDLE cycle. A disable during IDLE takes effect in that same cycle, because the input is combinational.
- Reset mid-packet: state returns to IDLE and any output beat is dropped. The upstream remainder of the packet is not flushed; upstream reset is coordinated at system level.

Decomposition:
- Shared package upb_sched_pkg holds the state enum (IDLE, XFER) and the function rr_pick(cand, ptr) returning index+valid.
- Sub-module rr_arbiter: combinational, a masked priority encoder plus wrap. Exhaustively testable on its own.

Test Plan:
1. Port 2 only holds a 3-beat packet, rr_ptr=0 → in_rd[2] high for 3 consecutive cycles; out_wr 1 cycle later; out_src=2; out_last on the 3rd beat; pkt_count=1.
2. All 4 ports each hold two 1-beat packets → out_src sequence 0,1,2,3,0,1,2,3 on consecutive cycles with no gaps.
3. Port 0 holds a 4-beat packet, port 1 holds a 1-beat packet, arriving together → beats 0,0,0,0 then 1; no interleave.
4. out_almost_full asserted for 5 cycles mid-packet → no in_rd during those cycles; stream resumes with beat order and count intact; out_wr gap of 5 cycles.
5. in_empty[grant]=1 for 3 cycles mid-packet while port 3 is non-empty → grant held; port 3 not popped until the last beat of the current packet.
6. port_enable=4'b1101 with all ports non-empty → port 1 never granted; deasserting port_enable[0] mid-packet still completes port 0's packet. Reset asserted mid-packet → next cycle out_wr=0, pkt_count=0, first grant goes to port 0.
